// File: rtl/pclk_rate_ctrl_if.sv
// Width-change handshake and PCLK-rate outputs of pclk_rate_ctrl.
// Chg_Cnt exists only when PCLK_RATE_CHG_CNT_EN is defined.
interface pclk_rate_ctrl_if;
  logic       Width_Req;
  logic [5:0] Req_Width;
  logic       Width_Ack;
  logic       Width_Err;
  logic [5:0] Active_Width;
  logic       PCLK_En;
  logic [1:0] Slot_Idx;
  logic       Busy;
`ifdef PCLK_RATE_CHG_CNT_EN
  logic [7:0] Chg_Cnt;
`endif

  modport master (
    output Width_Req, Req_Width,
    input  Width_Ack, Width_Err, Active_Width, PCLK_En, Slot_Idx, Busy
`ifdef PCLK_RATE_CHG_CNT_EN
    , input Chg_Cnt
`endif
  );

  modport slave (
    input  Width_Req, Req_Width,
    output Width_Ack, Width_Err, Active_Width, PCLK_En, Slot_Idx, Busy
`ifdef PCLK_RATE_CHG_CNT_EN
    , output Chg_Cnt
`endif
  );
endinterface

// File: rtl/pclk_rate_ctrl.sv
// Word_CLK -> PCLK rate sequencer (div 1/2/4) with req/ack bus-width change.
// Optional PCLK_RATE_CHG_CNT_EN adds the saturating Chg_Cnt ratio-change counter.
module pclk_rate_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [5:0]  RST_WIDTH     = 6'd8
) (
  input logic             Word_CLK,
  input logic             Rst,
  pclk_rate_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, PEND, SETTLE, ACK} state_e;

  localparam int unsigned   SW        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES);

  function automatic logic [1:0] top_slot(input logic [5:0] w);
    case (w)
      6'd16:   top_slot = 2'd1;
      6'd32:   top_slot = 2'd3;
      default: top_slot = 2'd0;
    endcase
  endfunction

  function automatic logic legal_width(input logic [5:0] w);
    legal_width = (w == 6'd8) || (w == 6'd16) || (w == 6'd32);
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    div_q, div_d, div_step;
  logic [5:0]    width_q, width_d;
  logic [5:0]    tgt_q, tgt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          armed_q, armed_d;
  logic          err_d;

  logic          pclk_en_q;
  logic [1:0]    slot_q;
  logic          ack_q;
  logic          err_q;
  logic          busy_q;
  logic [5:0]    aw_q;

`ifdef PCLK_RATE_CHG_CNT_EN
  logic          chg_q, chg_d;
  logic [7:0]    cnt_q, cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    width_d  = width_q;
    tgt_d    = tgt_q;
    settle_d = settle_q;
    armed_d  = armed_q;
    err_d    = 1'b0;
`ifdef PCLK_RATE_CHG_CNT_EN
    chg_d    = chg_q;
    cnt_d    = cnt_q;
`endif
    div_step = (div_q == top_slot(width_q)) ? '0 : div_q + 2'd1;

    case (state_q)
      RUN: begin
        div_d = div_step;
        if (bus.Width_Req && armed_q) begin
          if (!legal_width(bus.Req_Width)) begin
            err_d = 1'b1;
          end else if (bus.Req_Width == width_q) begin
            state_d = ACK;
          end else begin
            tgt_d   = bus.Req_Width;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        // Switch only on the last slot of the old PCLK word.
        if (div_q == top_slot(width_q)) begin
          width_d  = tgt_q;
          div_d    = '0;
          settle_d = SETTLE_LD;
          state_d  = (SETTLE_CYCLES == 0) ? ACK : SETTLE;
`ifdef PCLK_RATE_CHG_CNT_EN
          chg_d    = 1'b1;
`endif
        end else begin
          div_d = div_step;
        end
      end
      SETTLE: begin
        div_d    = '0;
        settle_d = settle_q - SW'(1);
        if (settle_q == SW'(1)) begin
          state_d = ACK;
        end
      end
      default: begin
        div_d   = div_step;
        state_d = RUN;
`ifdef PCLK_RATE_CHG_CNT_EN
        chg_d   = 1'b0;
        if (chg_q && (cnt_q != '1)) begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
    endcase

    // One request per Req high phase: disarm on Ack/Err, re-arm once Req is seen low.
    if ((state_q == ACK) || err_d) begin
      armed_d = 1'b0;
    end else if (!bus.Width_Req) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge Word_CLK) begin
    if (Rst) begin
      state_q   <= RUN;
      div_q     <= '0;
      width_q   <= RST_WIDTH;
      tgt_q     <= RST_WIDTH;
      settle_q  <= '0;
      armed_q   <= 1'b1;
      pclk_en_q <= 1'b0;
      slot_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      aw_q      <= RST_WIDTH;
`ifdef PCLK_RATE_CHG_CNT_EN
      chg_q     <= 1'b0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      width_q   <= width_d;
      tgt_q     <= tgt_d;
      settle_q  <= settle_d;
      armed_q   <= armed_d;
      // Outputs present the state of the previous cycle, one register stage deep.
      pclk_en_q <= (state_q != SETTLE) && (div_q == '0);
      slot_q    <= div_q;
      ack_q     <= (state_q == ACK);
      err_q     <= err_d;
      busy_q    <= (state_q == PEND) || (state_q == SETTLE);
      aw_q      <= width_q;
`ifdef PCLK_RATE_CHG_CNT_EN
      chg_q     <= chg_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.PCLK_En      = pclk_en_q;
  assign bus.Slot_Idx     = slot_q;
  assign bus.Width_Ack    = ack_q;
  assign bus.Width_Err    = err_q;
  assign bus.Busy         = busy_q;
  assign bus.Active_Width = aw_q;
`ifdef PCLK_RATE_CHG_CNT_EN
  assign bus.Chg_Cnt      = cnt_q;
`endif
endmodule

// File: tb/tb_pclk_rate_ctrl.sv
// Randomized bench for pclk_rate_ctrl against a cycle-indexed expectation timeline.
// Honors PCLK_RATE_CHG_CNT_EN for the Chg_Cnt output.
module tb_pclk_rate_ctrl;
  localparam int unsigned SETTLE = 4;
  localparam int          MAXC   = 4000;

  logic Word_CLK = 1'b0;
  logic Rst;
  pclk_rate_ctrl_if bus ();

  pclk_rate_ctrl #(.SETTLE_CYCLES(SETTLE), .RST_WIDTH(6'd8)) dut (
    .Word_CLK(Word_CLK),
    .Rst     (Rst),
    .bus     (bus)
  );

  always #5 Word_CLK = ~Word_CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Expected outputs per output cycle (cycle n = interval after the n-th rising edge).
  bit exp_en   [MAXC];
  int exp_slot [MAXC];
  bit exp_busy [MAXC];
  bit exp_ack  [MAXC];
  bit exp_err  [MAXC];
  int exp_aw   [MAXC];
  int exp_cc   [MAXC];

  int m_anchor, m_r, m_aw, m_cc;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int ratio_of(input int w);
    if (w == 16) return 2;
    if (w == 32) return 4;
    return 1;
  endfunction

  function automatic bit is_legal(input int w);
    return (w == 8) || (w == 16) || (w == 32);
  endfunction

  task automatic fill_cadence(input int from, input int anchor, input int r, input int w, input int cc);
    for (int c = from; c < MAXC; c++) begin
      exp_en[c]   = ((c - anchor) % r) == 0;
      exp_slot[c] = (c - anchor) % r;
      exp_busy[c] = 1'b0;
      exp_ack[c]  = 1'b0;
      exp_err[c]  = 1'b0;
      exp_aw[c]   = w;
      exp_cc[c]   = cc;
    end
  endtask

  task automatic check_all();
    check_eq("pclk_en",  int'(bus.PCLK_En),      int'(exp_en[cyc]));
    check_eq("slot_idx", int'(bus.Slot_Idx),     exp_slot[cyc]);
    check_eq("busy",     int'(bus.Busy),         int'(exp_busy[cyc]));
    check_eq("ack",      int'(bus.Width_Ack),    int'(exp_ack[cyc]));
    check_eq("err",      int'(bus.Width_Err),    int'(exp_err[cyc]));
    check_eq("width",    int'(bus.Active_Width), exp_aw[cyc]);
`ifdef PCLK_RATE_CHG_CNT_EN
    check_eq("chg_cnt",  int'(bus.Chg_Cnt),      exp_cc[cyc]);
`endif
  endtask

  task automatic tick();
    @(posedge Word_CLK);
    cyc++;
    @(negedge Word_CLK);
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    check_all();
  endtask

  // Reset held for k cycles starting at the next rising edge; width 8 resumes afterwards.
  task automatic apply_reset(input int k);
    int n;
    n = cyc;
    Rst = 1'b1;
    bus.Width_Req = 1'b0;
    for (int c = n + 1; c <= n + k; c++) begin
      exp_en[c] = 1'b0; exp_slot[c] = 0; exp_busy[c] = 1'b0;
      exp_ack[c] = 1'b0; exp_err[c] = 1'b0; exp_aw[c] = 8; exp_cc[c] = 0;
    end
    fill_cadence(n + k + 1, n + k + 1, 1, 8, 0);
    m_anchor = n + k + 1; m_r = 1; m_aw = 8; m_cc = 0;
    repeat (k) tick();
    Rst = 1'b0;
  endtask

  // Raises Req now and predicts the response: resp = Ack/Err cycle, blk_lo = first settle cycle.
  task automatic issue_req(input int w, output int resp, output int blk_lo);
    int n, q, a, cc;
    n = cyc;
    bus.Width_Req = 1'b1;
    bus.Req_Width = 6'(w);
    blk_lo = 0;
    if (!is_legal(w)) begin
      resp = n + 1;
      exp_err[n + 1] = 1'b1;
    end else if (w == m_aw) begin
      resp = n + 2;
      exp_ack[n + 2] = 1'b1;
    end else begin
      q = n + 2;
      while (((q - m_anchor) % m_r) != (m_r - 1)) q++;
      for (int c = n + 2; c <= q; c++) exp_busy[c] = 1'b1;
      a  = q + int'(SETTLE) + 1;
      cc = (m_cc < 255) ? m_cc + 1 : 255;
      fill_cadence(a, a, ratio_of(w), w, cc);
      for (int c = q + 1; c < a; c++) begin
        exp_en[c] = 1'b0; exp_slot[c] = 0; exp_busy[c] = 1'b1; exp_aw[c] = w;
      end
      exp_ack[a] = 1'b1;
      m_anchor = a; m_r = ratio_of(w); m_aw = w; m_cc = cc;
      resp = a;
      blk_lo = q + 1;
    end
  endtask

  task automatic do_req(input int w, input int hold);
    int resp, blk;
    issue_req(w, resp, blk);
    while (cyc < resp) tick();
    repeat (hold) tick();
    bus.Width_Req = 1'b0;
    tick();
  endtask

  function automatic int pick_width();
    int w;
    case ($urandom_range(0, 3))
      0: w = 8;
      1: w = 16;
      2: w = 32;
      default: begin
        w = $urandom_range(0, 63);
        while (is_legal(w)) w = $urandom_range(0, 63);
      end
    endcase
    return w;
  endfunction

  initial begin
    #(MAXC * 10 + 1000);
    $display("FAIL watchdog cyc=%0d limit=%0d", cyc, MAXC);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int resp, blk, op, w, k, guard;
    bus.Width_Req = 1'b0;
    bus.Req_Width = 6'd8;
    apply_reset(3);

    // Width 8 idle: enable every cycle, slot 0.
    repeat (10) tick();

    // 8 -> 32, then 32 -> 16 requested while slot 1 is on the bus.
    do_req(32, 0);
    repeat (6) tick();
    guard = 0;
    while (exp_slot[cyc] != 1 && guard < 8) begin tick(); guard++; end
    do_req(16, 0);
    repeat (6) tick();

    // Illegal width with Req held: single Err only.
    do_req(12, 3);
    repeat (2) tick();

    // Same width: fast Ack, no Busy, cadence untouched.
    do_req(16, 2);
    repeat (3) tick();

    // Back to 8, then reset in the middle of an 8 -> 32 settle window.
    do_req(8, 0);
    repeat (2) tick();
    issue_req(32, resp, blk);
    while (cyc < blk + 1) tick();
    bus.Width_Req = 1'b0;
    apply_reset(2);
    repeat (4) tick();

    for (int i = 0; i < 60 && cyc < MAXC - 200; i++) begin
      op = $urandom_range(0, 9);
      w  = pick_width();
      repeat ($urandom_range(0, 4)) tick();
      if (op == 9) begin
        issue_req(w, resp, blk);
        k = $urandom_range(0, resp - cyc - 1);
        repeat (k) tick();
        bus.Width_Req = 1'b0;
        apply_reset($urandom_range(1, 3));
        tick();
      end else begin
        do_req(w, $urandom_range(0, 3));
      end
    end
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
